// File: rtl/lzd_norm_arbiter_pkg.sv
// lzd_norm_arbiter_pkg: shared widths and requester id encoding
package lzd_norm_arbiter_pkg;
  localparam int BIAS = 7;
  localparam int W_DEF = 2 * BIAS + 1;
  localparam int CW_DEF = $clog2(W_DEF + 1);
  localparam int TW_DEF = 4;
  localparam logic REQ_ADD = 1'b0;
  localparam logic REQ_MUL = 1'b1;
endpackage

// File: rtl/lzd_norm_arbiter_if.sv
// lzd_norm_arbiter_if: two requester ports and the result port of the shared normalizer
interface lzd_norm_arbiter_if
  import lzd_norm_arbiter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1),
  parameter int TW = TW_DEF
);
  logic          req0_vld;
  logic          req0_rdy;
  logic [W-1:0]  req0_data;
  logic [TW-1:0] req0_tag;
  logic          req1_vld;
  logic          req1_rdy;
  logic [W-1:0]  req1_data;
  logic [TW-1:0] req1_tag;
  logic          res_vld;
  logic          res_rdy;
  logic          res_id;
  logic [TW-1:0] res_tag;
  logic [CW-1:0] res_lz;
  logic [W-1:0]  res_norm;
  logic          res_zero;
  modport master (
    output req0_vld, req0_data, req0_tag, req1_vld, req1_data, req1_tag, res_rdy,
    input  req0_rdy, req1_rdy, res_vld, res_id, res_tag, res_lz, res_norm, res_zero
  );
  modport slave (
    input  req0_vld, req0_data, req0_tag, req1_vld, req1_data, req1_tag, res_rdy,
    output req0_rdy, req1_rdy, res_vld, res_id, res_tag, res_lz, res_norm, res_zero
  );
endinterface

// File: rtl/lzd_norm_arbiter_lzd.sv
// lzd_norm_arbiter_lzd: combinational leading-zero count, returns N for all-zero input
module lzd_norm_arbiter_lzd
  import lzd_norm_arbiter_pkg::*;
#(
  parameter int N  = W_DEF,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  in_data,
  input  logic          in_vld,
  output logic [CW-1:0] cnt,
  output logic          out_vld
);
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++)
      if (in_data[i]) cnt = CW'(N - 1 - i);
  end
  assign out_vld = in_vld;
endmodule

// File: rtl/lzd_norm_arbiter.sv
// lzd_norm_arbiter: round-robin two-stage sequencer sharing one LZD and normalizing shifter
module lzd_norm_arbiter
  import lzd_norm_arbiter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1),
  parameter int TW = TW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  lzd_norm_arbiter_if.slave bus
);
  logic          s1_adv, s2_adv, gnt_id, hs, last_grant, s1_vld, s1_id, lzd_vld_unused;
  logic [W-1:0]  s1_data;
  logic [TW-1:0] s1_tag;
  logic [CW-1:0] lz;
  assign s2_adv = ~bus.res_vld | bus.res_rdy;
  assign s1_adv = ~s1_vld | s2_adv;
  assign gnt_id = (bus.req1_vld && (!bus.req0_vld || last_grant == REQ_ADD)) ? REQ_MUL : REQ_ADD;
  assign bus.req0_rdy = rst_n & s1_adv & bus.req0_vld & (gnt_id == REQ_ADD);
  assign bus.req1_rdy = rst_n & s1_adv & bus.req1_vld & (gnt_id == REQ_MUL);
  assign hs = bus.req0_rdy | bus.req1_rdy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_id      <= REQ_ADD;
      s1_data    <= '0;
      s1_tag     <= '0;
      last_grant <= REQ_MUL;
    end else if (s1_adv) begin
      s1_vld  <= hs;
      s1_id   <= gnt_id;
      s1_data <= (gnt_id == REQ_MUL) ? bus.req1_data : bus.req0_data;
      s1_tag  <= (gnt_id == REQ_MUL) ? bus.req1_tag : bus.req0_tag;
      if (hs) last_grant <= gnt_id;
    end
  end
  lzd_norm_arbiter_lzd #(.N(W), .CW(CW)) u_lzd (
    .in_data (s1_data),
    .in_vld  (s1_vld),
    .cnt     (lz),
    .out_vld (lzd_vld_unused)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_vld  <= 1'b0;
      bus.res_id   <= 1'b0;
      bus.res_tag  <= '0;
      bus.res_lz   <= '0;
      bus.res_norm <= '0;
      bus.res_zero <= 1'b0;
    end else if (s2_adv) begin
      bus.res_vld  <= s1_vld;
      bus.res_id   <= s1_id;
      bus.res_tag  <= s1_tag;
      bus.res_lz   <= lz;
      bus.res_norm <= s1_data << lz;
      bus.res_zero <= s1_data == '0;
    end
  end
endmodule

// File: tb/tb_lzd_norm_arbiter.sv
// tb_lzd_norm_arbiter: directed scoreboard bench for the shared LZD normalizer
module tb_lzd_norm_arbiter;
  localparam int W = 15, CW = 4, TW = 4;
  typedef struct packed {
    logic          id;
    logic [TW-1:0] tag;
    logic [CW-1:0] lz;
    logic [W-1:0]  norm;
    logic          zero;
  } res_t;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  lzd_norm_arbiter_if #(.W(W), .CW(CW), .TW(TW)) bus ();
  lzd_norm_arbiter #(.W(W), .CW(CW), .TW(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  res_t sb[$];
  res_t r;
  int n_chk = 0, n_fail = 0, n_acc = 0, n_pop = 0, rem0 = 0, rem1 = 0, acc0, pop0, k;
  logic hs0 = 0, hs1 = 0;
  logic [TW-1:0] tag_ctr = 0;
  logic [W-1:0] hold_norm;
  logic [CW-1:0] hold_lz;
  logic [TW-1:0] hold_tag;
  function automatic res_t model(logic id, logic [TW-1:0] tag, logic [W-1:0] d);
    res_t m;
    m.id = id;
    m.tag = tag;
    m.norm = d;
    m.lz = '0;
    m.zero = (d == 0);
    if (m.zero) m.lz = CW'(W);
    else while (!m.norm[W-1]) begin
      m.norm = m.norm << 1;
      m.lz++;
    end
    return m;
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    hs0 = bus.req0_vld & bus.req0_rdy;
    hs1 = bus.req1_vld & bus.req1_rdy;
    if (hs0) begin sb.push_back(model(1'b0, bus.req0_tag, bus.req0_data)); n_acc++; end
    if (hs1) begin sb.push_back(model(1'b1, bus.req1_tag, bus.req1_data)); n_acc++; end
    if (bus.res_vld && bus.res_rdy) begin
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed unexpected result tag %0h, expected none", bus.res_tag);
      end
      if (sb.size() > 0) begin
        r = sb.pop_front();
        n_pop++;
        check("sb_id", bus.res_id, r.id);
        check("sb_tag", bus.res_tag, r.tag);
        check("sb_lz", bus.res_lz, r.lz);
        check("sb_norm", bus.res_norm, r.norm);
        check("sb_zero", bus.res_zero, r.zero);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (hs0) begin rem0--; tag_ctr++; bus.req0_data = W'($urandom); bus.req0_tag = tag_ctr; end
    if (hs1) begin rem1--; tag_ctr++; bus.req1_data = W'($urandom); bus.req1_tag = tag_ctr; end
    if (rem0 == 0) bus.req0_vld = 0;
    if (rem1 == 0) bus.req1_vld = 0;
  endtask
  task automatic run(int max);
    int n = 0;
    while ((rem0 > 0 || rem1 > 0 || sb.size() > 0) && n < max) begin
      step();
      n++;
    end
    check("drain_in_budget", n < max, 1);
  endtask
  task automatic do_reset();
    rst_n = 0;
    bus.req0_vld = 0;
    bus.req1_vld = 0;
    bus.res_rdy = 0;
    rem0 = 0;
    rem1 = 0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic send_one(logic [W-1:0] d, logic [TW-1:0] t, logic [CW-1:0] lz, logic [W-1:0] nrm, logic z);
    bus.req0_data = d;
    bus.req0_tag = t;
    bus.req0_vld = 1;
    rem0 = 1;
    @(negedge clk);
    check("one_rdy", bus.req0_rdy, 1);
    step();
    @(negedge clk);
    check("one_latency", bus.res_vld, 0);
    step();
    @(negedge clk);
    check("one_vld", bus.res_vld, 1);
    check("one_lz", bus.res_lz, lz);
    check("one_norm", bus.res_norm, nrm);
    check("one_zero", bus.res_zero, z);
    check("one_id", bus.res_id, 0);
    check("one_tag", bus.res_tag, t);
    step();
  endtask
  initial begin
    bus.req0_vld = 1;
    bus.req1_vld = 1;
    bus.req0_data = 15'h1234;
    bus.req1_data = 15'h0042;
    bus.req0_tag = 0;
    bus.req1_tag = 0;
    bus.res_rdy = 0;
    #2 rst_n = 0;
    @(negedge clk);
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_res_tag", bus.res_tag, 0);
    check("rst_res_lz", bus.res_lz, 0);
    check("rst_res_norm", bus.res_norm, 0);
    check("rst_res_zero", bus.res_zero, 0);
    check("rst_req0_rdy", bus.req0_rdy, 0);
    check("rst_req1_rdy", bus.req1_rdy, 0);
    do_reset();
    bus.res_rdy = 1;
    send_one(15'h0100, 4'd3, 4'd6, 15'h4000, 1'b0);
    send_one(15'h0000, 4'd4, 4'd15, 15'h0000, 1'b1);
    send_one(15'h7FFF, 4'd5, 4'd0, 15'h7FFF, 1'b0);
    send_one(15'h0001, 4'd6, 4'd14, 15'h4000, 1'b0);
    do_reset();
    bus.res_rdy = 1;
    bus.req0_data = W'($urandom);
    bus.req1_data = W'($urandom);
    bus.req0_vld = 1;
    bus.req1_vld = 1;
    rem0 = 4;
    rem1 = 4;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("alt_req0_rdy", bus.req0_rdy, c % 2 == 0);
      check("alt_req1_rdy", bus.req1_rdy, c % 2 == 1);
      if (c >= 2) begin
        check("alt_res_vld", bus.res_vld, 1);
        check("alt_res_id", bus.res_id, c % 2);
      end
      step();
    end
    run(20);
    bus.res_rdy = 0;
    bus.req0_data = W'($urandom);
    bus.req0_vld = 1;
    rem0 = 8;
    acc0 = n_acc;
    pop0 = n_pop;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_req0_rdy", bus.req0_rdy, c < 2);
      if (c == 2) begin
        check("bp_full_vld", bus.res_vld, 1);
        hold_norm = bus.res_norm;
        hold_lz = bus.res_lz;
        hold_tag = bus.res_tag;
      end
      if (c > 2) begin
        check("bp_hold_vld", bus.res_vld, 1);
        check("bp_hold_norm", bus.res_norm, hold_norm);
        check("bp_hold_lz", bus.res_lz, hold_lz);
        check("bp_hold_tag", bus.res_tag, hold_tag);
      end
      if (c == 5) check("bp_accepted", n_acc - acc0, 2);
      step();
    end
    bus.res_rdy = 1;
    run(40);
    check("bp_total_acc", n_acc - acc0, 8);
    check("bp_total_pop", n_pop - pop0, 8);
    bus.res_rdy = 0;
    bus.req0_data = W'($urandom);
    bus.req0_vld = 1;
    rem0 = 2;
    step();
    step();
    bus.req0_data = W'($urandom);
    bus.req1_data = W'($urandom);
    bus.req0_vld = 1;
    bus.req1_vld = 1;
    rem0 = 3;
    rem1 = 3;
    #1;
    check("mid_full_vld", bus.res_vld, 1);
    check("mid_full_rdy0", bus.req0_rdy, 0);
    check("mid_full_rdy1", bus.req1_rdy, 0);
    rst_n = 0;
    #1;
    check("mid_rst_vld", bus.res_vld, 0);
    check("mid_rst_rdy0", bus.req0_rdy, 0);
    check("mid_rst_rdy1", bus.req1_rdy, 0);
    sb.delete();
    rst_n = 1;
    bus.res_rdy = 1;
    @(negedge clk);
    check("post_rst_rdy0", bus.req0_rdy, 1);
    check("post_rst_rdy1", bus.req1_rdy, 0);
    run(40);
    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
